aq_biu_lpmd_ctrl: RTL and testbench
===================================

// Module: aq_biu_lpmd_ctrl
// PURPOSE
//  Consumes the CP0 low-power bits (cp0_biu_lpmd_b) and performs the SoC-side sleep handshake.
//  Blocks new bus requests and drains outstanding transactions, then runs a four-phase
//  sleep_req/sleep_ack handshake with the SoC power controller.
//  On wake, releases the handshake and holds the core stalled for a programmable clock-restart delay.
//  Sits in BIU, between CP0 low-power FSM and sysio pads.
// PARAMETERS
//  WAKE_DLY  default 8    cycles from sleep_ack fall to wake_done pulse (1..255)
//  ACK_TMO   default 1023 max cycles waiting for sleep_ack rise (used only with macro)
//  CNT_W     default 10   counter width; must satisfy 2**CNT_W > max(WAKE_DLY, ACK_TMO)
// PORTS
//  forever_cpuclk     in   1  ungated core clock
//  cpurst             in   1  reset, synchronous, active-high
//  cp0_biu_lpmd_b     in   2  CP0 lpmd bits; 2'b11 = run, else = low-power request
//  biu_bus_idle       in   1  1 = no outstanding AXI/AHB transactions
//  pad_biu_sleep_ack  in   1  SoC power-controller ack (synchronised externally)
//  pad_biu_wakeup     in   1  SoC wake event (interrupt/debug), level
//  biu_req_block      out  1  blocks IFU/LSU from issuing new bus requests
//  biu_pad_sleep_req  out  1  sleep request to SoC
//  biu_pad_lpmd_b     out  2  registered copy of the lpmd mode presented to SoC
//  biu_lpmd_wake_done out  1  one-cycle pulse when the wake sequence completes
//  biu_lpmd_state     out  3  current FSM state (debug/observability)
//  biu_lpmd_ack_err   out  1  sticky ack-timeout flag (present only with macro; else tied 0)
// BEHAVIOUR
//  Reset (cpurst=1 at clock edge): state=RUN, req_block=0, sleep_req=0, lpmd_b=2'b11,
//   wake_done=0, ack_err=0, counter=0. Reset mid-handshake drops sleep_req immediately,
//   without waiting for ack to fall.
//  States (3'b encoding): RUN=000 DRAIN=001 REQ=010 SLEEP=011 WAKE=100.
//  RUN:   cp0_biu_lpmd_b!=11 -> DRAIN; latch mode into biu_pad_lpmd_b; req_block=1 next cycle.
//  DRAIN: req_block=1. cp0_biu_lpmd_b==11 (abort) -> RUN, lpmd_b=11, req_block=0.
//         Else biu_bus_idle=1 -> REQ. Abort has priority over idle.
//  REQ:   sleep_req=1. sleep_ack=1 -> SLEEP.
//         Abort or pad_biu_wakeup before ack -> WAKE (sleep_req drops).
//         Simultaneous ack and abort -> WAKE.
//  SLEEP: sleep_req=1, req_block=1. pad_biu_wakeup=1 or cp0_biu_lpmd_b==11 -> WAKE.
//  WAKE:  sleep_req=0; counter loads 0 on entry. Counter stays 0 while sleep_ack=1, then
//         increments. At count==WAKE_DLY-1 -> RUN; wake_done=1 for exactly one cycle;
//         req_block=0; lpmd_b=11.
//  Minimum wake latency: wake event -> wake_done = WAKE_DLY+1 cycles, given ack falls the
//   cycle after sleep_req falls.
//  Counter saturates; it never wraps.
//  sleep_req never rises again until ack has been seen low (four-phase rule).
//  biu_pad_lpmd_b changes only in RUN->DRAIN and on return to RUN.
// CONFIGURATION
//  Macro AQ_BIU_LPMD_ACK_TMO_EN.
//  Defined: in REQ, counter counts cycles without ack. At ACK_TMO -> WAKE, and
//   biu_lpmd_ack_err is set (sticky until cpurst).
//  Undefined: REQ waits indefinitely for ack; biu_lpmd_ack_err tied 0; no timeout logic.
// STRUCTURE
//  Package aq_biu_lpmd_pkg: state encodings (RUN..WAKE), LPMD_RUN=2'b11, default
//   WAKE_DLY/ACK_TMO.
//  Sub-module aq_biu_lpmd_cnt: CNT_W saturating counter with clr/inc/sat ports,
//   shared by WAKE delay and ack timeout.
//  Top holds the FSM, output registers and macro-guarded timeout path.
// TESTING
//  1 Normal sleep: lpmd_b=00, bus_idle=1, ack rises 3 cycles after req; wakeup pulse; ack falls
//    -> states RUN,DRAIN,REQ,SLEEP,WAKE,RUN; wake_done once, WAKE_DLY=8 cycles after ack fall.
//  2 Drain stall: bus_idle=0 for 20 cycles -> sleep_req stays 0 and req_block=1 throughout;
//    REQ entered the cycle after idle.
//  3 Abort in DRAIN: lpmd_b returns 11 at cycle 2 -> RUN, req_block=0, sleep_req never asserted.
//  4 Wake before ack in REQ: wakeup=1 with ack=0 -> WAKE; sleep_req=0 next cycle; wake_done
//    after 8 cycles.
//  5 Reset in SLEEP: cpurst=1 -> next cycle state=RUN, sleep_req=0, lpmd_b=11, ack_err=0.
//  6 Macro on, ACK_TMO=16: ack never rises -> WAKE after 16 REQ cycles, ack_err=1 and sticky;
//    macro off: REQ held for 100 cycles.

Source files
------------

// File: rtl/aq_biu_lpmd_pkg.sv
// rtl/aq_biu_lpmd_pkg.sv - shared encodings and defaults for the BIU low-power controller
package aq_biu_lpmd_pkg;

  // FSM state encodings, exported as-is on biu_lpmd_state
  typedef enum logic [2:0] {
    ST_RUN   = 3'b000,
    ST_DRAIN = 3'b001,
    ST_REQ   = 3'b010,
    ST_SLEEP = 3'b011,
    ST_WAKE  = 3'b100
  } lpmd_state_e;

  // CP0 lpmd value meaning "run"; anything else requests low power
  localparam logic [1:0] LPMD_RUN = 2'b11;

  localparam int WAKE_DLY_DEF = 8;
  localparam int ACK_TMO_DEF  = 1023;
  localparam int CNT_W_DEF    = 10;

  // Larger of two elaboration-time integers
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/aq_biu_lpmd_ctrl_if.sv
// rtl/aq_biu_lpmd_ctrl_if.sv - CP0/bus/pad handshake bundle of the low-power controller
interface aq_biu_lpmd_ctrl_if;

  logic [1:0] cp0_biu_lpmd_b;
  logic       biu_bus_idle;
  logic       pad_biu_sleep_ack;
  logic       pad_biu_wakeup;
  logic       biu_req_block;
  logic       biu_pad_sleep_req;
  logic [1:0] biu_pad_lpmd_b;
  logic       biu_lpmd_wake_done;
  logic [2:0] biu_lpmd_state;
  logic       biu_lpmd_ack_err;

  // Environment side: CP0, bus tracker and SoC pads
  modport master (
    output cp0_biu_lpmd_b, biu_bus_idle, pad_biu_sleep_ack, pad_biu_wakeup,
    input  biu_req_block, biu_pad_sleep_req, biu_pad_lpmd_b,
           biu_lpmd_wake_done, biu_lpmd_state, biu_lpmd_ack_err
  );

  // Controller side
  modport slave (
    input  cp0_biu_lpmd_b, biu_bus_idle, pad_biu_sleep_ack, pad_biu_wakeup,
    output biu_req_block, biu_pad_sleep_req, biu_pad_lpmd_b,
           biu_lpmd_wake_done, biu_lpmd_state, biu_lpmd_ack_err
  );

endinterface

// File: rtl/aq_biu_lpmd_cnt.sv
// rtl/aq_biu_lpmd_cnt.sv - saturating counter shared by wake delay and ack timeout
module aq_biu_lpmd_cnt #(
  parameter int CNT_W = 10,
  parameter int MAX   = (1 << CNT_W) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX);

  assign sat = (cnt == MAX_V);

  // Clear wins over increment; the count holds at MAX instead of wrapping
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/aq_biu_lpmd_ctrl.sv
// rtl/aq_biu_lpmd_ctrl.sv - BIU sleep handshake controller (optional ack timeout: AQ_BIU_LPMD_ACK_TMO_EN)
module aq_biu_lpmd_ctrl
  import aq_biu_lpmd_pkg::*;
#(
  parameter int WAKE_DLY = WAKE_DLY_DEF,
  parameter int ACK_TMO  = ACK_TMO_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  aq_biu_lpmd_ctrl_if.slave bus
);

  localparam int               MAX_CNT   = max_int(WAKE_DLY, ACK_TMO);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_DLY - 1);

  lpmd_state_e      state_q;
  logic             req_block_q;
  logic             sleep_req_q;
  logic [1:0]       lpmd_b_q;
  logic             wake_done_q;

  logic             cnt_clr;
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt;
  logic             cnt_sat;

  logic             abort;
  logic             wake_last;

  assign abort     = (bus.cp0_biu_lpmd_b == LPMD_RUN);
  // Saturation is a backstop only; the count reaches WAKE_LAST first
  assign wake_last = (cnt == WAKE_LAST) || cnt_sat;

`ifdef AQ_BIU_LPMD_ACK_TMO_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TMO - 1);
  logic tmo_hit;
  logic ack_err_q;
  assign tmo_hit = (cnt == TMO_LAST);
`endif

  aq_biu_lpmd_cnt #(
    .CNT_W (CNT_W),
    .MAX   (MAX_CNT)
  ) u_cnt (
    .clk (forever_cpuclk),
    .rst (cpurst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .cnt (cnt),
    .sat (cnt_sat)
  );

  // Counter steering: zero outside REQ/WAKE so each phase starts from 0 on entry
  always_comb begin
    cnt_clr = 1'b1;
    cnt_inc = 1'b0;
    unique case (state_q)
`ifdef AQ_BIU_LPMD_ACK_TMO_EN
      ST_REQ: begin
        cnt_inc = 1'b1;
        cnt_clr = abort || bus.pad_biu_wakeup || tmo_hit;
      end
`endif
      ST_WAKE: begin
        // Clock-restart delay only starts once the SoC has dropped its ack
        cnt_clr = bus.pad_biu_sleep_ack;
        cnt_inc = !bus.pad_biu_sleep_ack;
      end
      default: begin
      end
    endcase
  end

  // Handshake FSM with registered outputs
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q     <= ST_RUN;
      req_block_q <= 1'b0;
      sleep_req_q <= 1'b0;
      lpmd_b_q    <= LPMD_RUN;
      wake_done_q <= 1'b0;
`ifdef AQ_BIU_LPMD_ACK_TMO_EN
      ack_err_q   <= 1'b0;
`endif
    end else begin
      wake_done_q <= 1'b0;
      unique case (state_q)
        ST_RUN: begin
          if (!abort) begin
            state_q     <= ST_DRAIN;
            lpmd_b_q    <= bus.cp0_biu_lpmd_b;
            req_block_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (abort) begin
            state_q     <= ST_RUN;
            lpmd_b_q    <= LPMD_RUN;
            req_block_q <= 1'b0;
          end else if (bus.biu_bus_idle && !bus.pad_biu_sleep_ack) begin
            // Four-phase rule: a new request waits until the previous ack is gone
            state_q     <= ST_REQ;
            sleep_req_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (abort || bus.pad_biu_wakeup) begin
            state_q     <= ST_WAKE;
            sleep_req_q <= 1'b0;
          end else if (bus.pad_biu_sleep_ack) begin
            state_q     <= ST_SLEEP;
`ifdef AQ_BIU_LPMD_ACK_TMO_EN
          end else if (tmo_hit) begin
            state_q     <= ST_WAKE;
            sleep_req_q <= 1'b0;
            ack_err_q   <= 1'b1;
`endif
          end
        end
        ST_SLEEP: begin
          if (abort || bus.pad_biu_wakeup) begin
            state_q     <= ST_WAKE;
            sleep_req_q <= 1'b0;
          end
        end
        ST_WAKE: begin
          if (!bus.pad_biu_sleep_ack && wake_last) begin
            state_q     <= ST_RUN;
            wake_done_q <= 1'b1;
            req_block_q <= 1'b0;
            lpmd_b_q    <= LPMD_RUN;
          end
        end
        default: begin
          state_q     <= ST_RUN;
          sleep_req_q <= 1'b0;
          req_block_q <= 1'b0;
          lpmd_b_q    <= LPMD_RUN;
        end
      endcase
    end
  end

  assign bus.biu_req_block      = req_block_q;
  assign bus.biu_pad_sleep_req  = sleep_req_q;
  assign bus.biu_pad_lpmd_b     = lpmd_b_q;
  assign bus.biu_lpmd_wake_done = wake_done_q;
  assign bus.biu_lpmd_state     = state_q;
`ifdef AQ_BIU_LPMD_ACK_TMO_EN
  assign bus.biu_lpmd_ack_err   = ack_err_q;
`else
  assign bus.biu_lpmd_ack_err   = 1'b0;
`endif

endmodule

// File: tb/tb_aq_biu_lpmd_ctrl.sv
// tb/tb_aq_biu_lpmd_ctrl.sv - directed self-checking bench for aq_biu_lpmd_ctrl
module tb_aq_biu_lpmd_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  aq_biu_lpmd_ctrl_if bus_if ();

  aq_biu_lpmd_ctrl #(
    .WAKE_DLY (8),
    .ACK_TMO  (16),
    .CNT_W    (10)
  ) dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .bus            (bus_if)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [2:0] exp);
    checks++;
    assert (bus_if.biu_lpmd_state === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, bus_if.biu_lpmd_state, exp);
    end
  endtask

  task automatic chk_lp(input string tag, input logic [1:0] exp);
    checks++;
    assert (bus_if.biu_pad_lpmd_b === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, bus_if.biu_pad_lpmd_b, exp);
    end
  endtask

  initial begin
    bus_if.cp0_biu_lpmd_b    = 2'b11;
    bus_if.biu_bus_idle      = 1'b1;
    bus_if.pad_biu_sleep_ack = 1'b0;
    bus_if.pad_biu_wakeup    = 1'b0;
    step(2);

    // Reset state
    chk_st("rst_state", 3'd0);
    chk1("rst_block", bus_if.biu_req_block, 1'b0);
    chk1("rst_req", bus_if.biu_pad_sleep_req, 1'b0);
    chk_lp("rst_lpmd", 2'b11);
    chk1("rst_wd", bus_if.biu_lpmd_wake_done, 1'b0);
    chk1("rst_err", bus_if.biu_lpmd_ack_err, 1'b0);
    rst = 1'b0;
    step(1);

    // 1: normal sleep sequence
    bus_if.cp0_biu_lpmd_b = 2'b00;
    step(1);
    chk_st("t1_drain", 3'd1);
    chk1("t1_block", bus_if.biu_req_block, 1'b1);
    chk_lp("t1_lpmd", 2'b00);
    step(1);
    chk_st("t1_req", 3'd2);
    chk1("t1_sreq", bus_if.biu_pad_sleep_req, 1'b1);
    step(2);
    chk_st("t1_req_wait", 3'd2);
    bus_if.pad_biu_sleep_ack = 1'b1;
    step(1);
    chk_st("t1_sleep", 3'd3);
    chk1("t1_sleep_sreq", bus_if.biu_pad_sleep_req, 1'b1);
    bus_if.pad_biu_wakeup = 1'b1;
    bus_if.cp0_biu_lpmd_b = 2'b11;
    step(1);
    chk_st("t1_wake", 3'd4);
    chk1("t1_wake_sreq", bus_if.biu_pad_sleep_req, 1'b0);
    chk1("t1_wake_block", bus_if.biu_req_block, 1'b1);
    bus_if.pad_biu_wakeup    = 1'b0;
    bus_if.pad_biu_sleep_ack = 1'b0;
    step(7);
    chk_st("t1_wake_hold", 3'd4);
    chk1("t1_wd_early", bus_if.biu_lpmd_wake_done, 1'b0);
    step(1);
    chk_st("t1_run", 3'd0);
    chk1("t1_wd", bus_if.biu_lpmd_wake_done, 1'b1);
    chk1("t1_run_block", bus_if.biu_req_block, 1'b0);
    chk_lp("t1_run_lpmd", 2'b11);
    step(1);
    chk1("t1_wd_pulse", bus_if.biu_lpmd_wake_done, 1'b0);

    // 2: drain stall while bus busy
    bus_if.biu_bus_idle   = 1'b0;
    bus_if.cp0_biu_lpmd_b = 2'b01;
    step(1);
    for (int i = 0; i < 20; i++) begin
      chk1("t2_stall_sreq", bus_if.biu_pad_sleep_req, 1'b0);
      chk1("t2_stall_block", bus_if.biu_req_block, 1'b1);
      chk_st("t2_stall_state", 3'd1);
      step(1);
    end
    bus_if.biu_bus_idle = 1'b1;
    step(1);
    chk_st("t2_req", 3'd2);
    chk1("t2_sreq", bus_if.biu_pad_sleep_req, 1'b1);
    bus_if.cp0_biu_lpmd_b = 2'b11;
    step(1);
    chk_st("t2_abort_wake", 3'd4);
    step(8);
    chk1("t2_wd", bus_if.biu_lpmd_wake_done, 1'b1);

    // 3: abort in DRAIN, and abort beating idle
    bus_if.biu_bus_idle   = 1'b0;
    bus_if.cp0_biu_lpmd_b = 2'b00;
    step(2);
    chk_st("t3_drain", 3'd1);
    chk1("t3_sreq", bus_if.biu_pad_sleep_req, 1'b0);
    bus_if.cp0_biu_lpmd_b = 2'b11;
    step(1);
    chk_st("t3_run", 3'd0);
    chk1("t3_block", bus_if.biu_req_block, 1'b0);
    chk1("t3_sreq_end", bus_if.biu_pad_sleep_req, 1'b0);
    chk_lp("t3_lpmd", 2'b11);
    bus_if.cp0_biu_lpmd_b = 2'b01;
    step(1);
    chk_lp("t3b_lpmd", 2'b01);
    bus_if.cp0_biu_lpmd_b = 2'b11;
    bus_if.biu_bus_idle   = 1'b1;
    step(1);
    chk_st("t3b_prio", 3'd0);

    // 4: wakeup before ack in REQ
    bus_if.cp0_biu_lpmd_b = 2'b10;
    step(1);
    chk_lp("t4_lpmd", 2'b10);
    step(1);
    chk_st("t4_req", 3'd2);
    bus_if.pad_biu_wakeup = 1'b1;
    step(1);
    chk_st("t4_wake", 3'd4);
    chk1("t4_sreq", bus_if.biu_pad_sleep_req, 1'b0);
    bus_if.pad_biu_wakeup = 1'b0;
    bus_if.cp0_biu_lpmd_b = 2'b11;
    step(7);
    chk1("t4_wd_early", bus_if.biu_lpmd_wake_done, 1'b0);
    step(1);
    chk1("t4_wd", bus_if.biu_lpmd_wake_done, 1'b1);

    // 4b: simultaneous ack and abort in REQ, ack held high in WAKE
    bus_if.cp0_biu_lpmd_b = 2'b00;
    step(2);
    chk_st("t4b_req", 3'd2);
    bus_if.pad_biu_sleep_ack = 1'b1;
    bus_if.cp0_biu_lpmd_b    = 2'b11;
    step(1);
    chk_st("t4b_wake", 3'd4);
    step(10);
    chk_st("t4b_ack_hold", 3'd4);
    bus_if.pad_biu_sleep_ack = 1'b0;
    step(7);
    chk1("t4b_wd_early", bus_if.biu_lpmd_wake_done, 1'b0);
    step(1);
    chk1("t4b_wd", bus_if.biu_lpmd_wake_done, 1'b1);

    // 5: reset in SLEEP, then four-phase guard against a stale ack
    bus_if.cp0_biu_lpmd_b = 2'b00;
    step(2);
    bus_if.pad_biu_sleep_ack = 1'b1;
    step(1);
    chk_st("t5_sleep", 3'd3);
    rst = 1'b1;
    step(1);
    chk_st("t5_state", 3'd0);
    chk1("t5_sreq", bus_if.biu_pad_sleep_req, 1'b0);
    chk_lp("t5_lpmd", 2'b11);
    chk1("t5_err", bus_if.biu_lpmd_ack_err, 1'b0);
    rst = 1'b0;
    step(2);
    chk_st("t5_ack_guard", 3'd1);
    chk1("t5_guard_sreq", bus_if.biu_pad_sleep_req, 1'b0);
    bus_if.pad_biu_sleep_ack = 1'b0;
    step(1);
    chk_st("t5_req", 3'd2);
    bus_if.cp0_biu_lpmd_b = 2'b11;
    step(9);
    chk1("t5_wd", bus_if.biu_lpmd_wake_done, 1'b1);

    // 6: ack never arrives
    bus_if.cp0_biu_lpmd_b = 2'b00;
    step(2);
    chk_st("t6_req", 3'd2);
`ifdef AQ_BIU_LPMD_ACK_TMO_EN
    step(15);
    chk_st("t6_req_last", 3'd2);
    chk1("t6_err_early", bus_if.biu_lpmd_ack_err, 1'b0);
    step(1);
    chk_st("t6_tmo_wake", 3'd4);
    chk1("t6_err", bus_if.biu_lpmd_ack_err, 1'b1);
    bus_if.cp0_biu_lpmd_b = 2'b11;
    step(8);
    chk1("t6_wd", bus_if.biu_lpmd_wake_done, 1'b1);
    step(3);
    chk1("t6_err_sticky", bus_if.biu_lpmd_ack_err, 1'b1);
`else
    step(100);
    chk_st("t6_req_held", 3'd2);
    chk1("t6_sreq_held", bus_if.biu_pad_sleep_req, 1'b1);
    chk1("t6_err_tied", bus_if.biu_lpmd_ack_err, 1'b0);
    bus_if.cp0_biu_lpmd_b = 2'b11;
    step(9);
    chk1("t6_wd", bus_if.biu_lpmd_wake_done, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
